// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared FSM/port types, segment bases and the access legality rule.
package mem_access_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_e;
   typedef enum logic {PORT_IF, PORT_DM} port_e;
   localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
   localparam logic [31:0] DATA_BASE = 32'h1001_0000;
   // Fetches must hit text; stores must not (text is write-protected); loads may read either.
   function automatic logic access_legal(input port_e port, input logic we, input logic text, input logic [1:0] lo);
      return (lo == 2'b00) && (port == PORT_IF ? text : !(we && text));
   endfunction
endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: 2-way round-robin grant between fetch and data; pointer moves on every grant.
module mem_rr_arbiter (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic req_if_i,
   input  logic req_dm_i,
   output logic gnt_valid_o,
   output logic gnt_dm_o
);
   logic pri_dm_q;
   assign gnt_valid_o = en_i && (req_if_i || req_dm_i);
   assign gnt_dm_o    = req_dm_i && (!req_if_i || pri_dm_q);
   always_ff @(posedge clk) begin
      if (reset) pri_dm_q <= 1'b0;
      else if (gnt_valid_o) pri_dm_q <= !gnt_dm_o;
   end
endmodule

// File: rtl/mem_access_master.sv
// mem_access_master: arbitrates fetch/data ports onto one memory, IDLE->ISSUE->ACK sequencing with legality checks.
// Optional performance counters are enabled with MEM_ACCESS_MASTER_PERF_EN.
module mem_access_master
   import mem_access_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int TEXT_SEL_BIT = 22
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [DATA_WIDTH-1:0] if_addr,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_ack,
   output logic                  if_err,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [DATA_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  dm_ack,
   output logic                  dm_err,
   output logic [DATA_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  mem_write,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  busy
`ifdef MEM_ACCESS_MASTER_PERF_EN
  ,output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_load_cnt,
   output logic [31:0]           perf_store_cnt,
   output logic [31:0]           perf_err_cnt,
   output logic [31:0]           perf_conflict_cnt
`endif
);
   state_e                state_q;
   port_e                 port_q, g_port;
   logic                  we_q, busy_q, gnt_valid, gnt_dm, g_we, g_legal;
   logic                  if_ack_q, if_err_q, dm_ack_q, dm_err_q;
   logic [DATA_WIDTH-1:0] addr_q, wdata_q, if_rdata_q, dm_rdata_q, g_addr, g_wdata;

   mem_rr_arbiter u_arb (
      .clk         (clk),
      .reset       (reset),
      .en_i        (state_q == IDLE),
      .req_if_i    (if_req),
      .req_dm_i    (dm_req),
      .gnt_valid_o (gnt_valid),
      .gnt_dm_o    (gnt_dm)
   );

   assign g_port  = gnt_dm ? PORT_DM : PORT_IF;
   assign g_addr  = gnt_dm ? dm_addr : if_addr;
   assign g_wdata = gnt_dm ? dm_wdata : '0;
   assign g_we    = gnt_dm && dm_we;
   assign g_legal = access_legal(g_port, g_we, g_addr[TEXT_SEL_BIT], g_addr[1:0]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         port_q     <= PORT_IF;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_ack_q   <= 1'b0;
         if_err_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         dm_err_q   <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (gnt_valid) begin
               addr_q   <= g_addr;
               wdata_q  <= g_wdata;
               we_q     <= g_we;
               port_q   <= g_port;
               busy_q   <= 1'b1;
               state_q  <= g_legal ? ISSUE : ACK;
               if_ack_q <= !g_legal && g_port == PORT_IF;
               if_err_q <= !g_legal && g_port == PORT_IF;
               dm_ack_q <= !g_legal && g_port == PORT_DM;
               dm_err_q <= !g_legal && g_port == PORT_DM;
            end
            ISSUE: begin
               state_q    <= ACK;
               if_ack_q   <= port_q == PORT_IF;
               dm_ack_q   <= port_q == PORT_DM;
               if_rdata_q <= port_q == PORT_IF ? mem_read_data : '0;
               dm_rdata_q <= (port_q == PORT_DM && !we_q) ? mem_read_data : '0;
            end
            default: begin
               state_q    <= IDLE;
               busy_q     <= 1'b0;
               if_ack_q   <= 1'b0;
               if_err_q   <= 1'b0;
               dm_ack_q   <= 1'b0;
               dm_err_q   <= 1'b0;
               if_rdata_q <= '0;
               dm_rdata_q <= '0;
            end
         endcase
      end
   end

   // Gated by reset so a store caught mid-ISSUE never reaches memory.
   assign mem_write      = state_q == ISSUE && we_q && !reset;
   assign mem_address    = addr_q;
   assign mem_write_data = wdata_q;
   assign if_rdata       = if_rdata_q;
   assign if_ack         = if_ack_q;
   assign if_err         = if_err_q;
   assign dm_rdata       = dm_rdata_q;
   assign dm_ack         = dm_ack_q;
   assign dm_err         = dm_err_q;
   assign busy           = busy_q;

`ifdef MEM_ACCESS_MASTER_PERF_EN
   logic [31:0] fetch_cnt_q, load_cnt_q, store_cnt_q, err_cnt_q, conflict_cnt_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q    <= '0;
         load_cnt_q     <= '0;
         store_cnt_q    <= '0;
         err_cnt_q      <= '0;
         conflict_cnt_q <= '0;
      end else begin
         fetch_cnt_q    <= fetch_cnt_q + 32'(if_ack_q);
         load_cnt_q     <= load_cnt_q + 32'(dm_ack_q && !we_q);
         store_cnt_q    <= store_cnt_q + 32'(dm_ack_q && we_q);
         err_cnt_q      <= err_cnt_q + 32'(if_err_q || dm_err_q);
         conflict_cnt_q <= conflict_cnt_q + 32'(state_q == IDLE && if_req && dm_req);
      end
   end
   assign perf_fetch_cnt    = fetch_cnt_q;
   assign perf_load_cnt     = load_cnt_q;
   assign perf_store_cnt    = store_cnt_q;
   assign perf_err_cnt      = err_cnt_q;
   assign perf_conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_mem_access_master.sv
// tb_mem_access_master: directed requests with a queue-based scoreboard checked by an ack monitor.
module tb_mem_access_master;
   typedef struct {
      bit          is_if;
      bit          err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0, reset = 1'b1;
   logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
   logic [31:0] if_rdata, dm_rdata, mem_address, mem_write_data, mem_read_data;
   logic        if_ack, if_err, dm_ack, dm_err, mem_write, busy;
`ifdef MEM_ACCESS_MASTER_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_load_cnt, perf_store_cnt, perf_err_cnt, perf_conflict_cnt;
`endif

   logic [31:0] mem [16];
   logic [3:0]  idx;
   bit          mem_ok = 1'b0;
   exp_t        q[$];
   exp_t        e;
   int          n_chk = 0, n_fail = 0, wr_cnt = 0;

   always #5 clk = ~clk;

   mem_access_master dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
      .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_write(mem_write),
      .mem_read_data(mem_read_data), .busy(busy)
`ifdef MEM_ACCESS_MASTER_PERF_EN
     ,.perf_fetch_cnt(perf_fetch_cnt), .perf_load_cnt(perf_load_cnt), .perf_store_cnt(perf_store_cnt),
      .perf_err_cnt(perf_err_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
   );

   // Word memory: text words at idx 8..15, data words at idx 0..7.
   assign idx           = {mem_address[22], mem_address[4:2]};
   assign mem_read_data = mem[idx];
   always @(posedge clk) begin
      if (!mem_ok) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 | 32'(i);
         mem[9]  <= 32'h2008_0005;
         mem[10] <= 32'h8C09_0000;
         mem[1]  <= 32'h1234_5678;
         mem_ok  <= 1'b1;
      end else if (mem_write) mem[idx] <= mem_write_data;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_write) wr_cnt++;
      if (if_ack || dm_ack) begin
         if (q.size() == 0) check("unexpected_ack", 32'({if_ack, dm_ack}), 32'h0);
         else begin
            e = q.pop_front();
            check("ack_port", 32'({if_ack, dm_ack}), 32'({e.is_if, !e.is_if}));
            check("ack_err", 32'({if_err, dm_err}), 32'({e.is_if && e.err, !e.is_if && e.err}));
            check("ack_rdata", e.is_if ? if_rdata : dm_rdata, e.rdata);
            check("other_rdata", e.is_if ? dm_rdata : if_rdata, 32'h0);
         end
      end
   end

   task automatic do_req(input string nm, input bit is_if, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat);
      int cyc, w0;
      cyc = 0;
      while (busy && cyc < 10) begin @(negedge clk); cyc++; end
      q.push_back('{is_if, exp_err, exp_rdata});
      w0 = wr_cnt;
      if (is_if) begin if_req = 1'b1; if_addr = addr; end
      else begin dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; end
      cyc = 1;
      do begin @(negedge clk); cyc++; end while (!(is_if ? if_ack : dm_ack) && cyc < 12);
      if_req = 1'b0;
      dm_req = 1'b0;
      check({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
      check({nm, "_writes"}, 32'(wr_cnt - w0), (we && !is_if && !exp_err) ? 32'd1 : 32'd0);
   endtask

   initial begin
      int acks, cyc, w0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_flags", 32'({if_ack, if_err, dm_ack, dm_err, mem_write, busy}), 32'h0);
      check("rst_if_rdata", if_rdata, 32'h0);
      check("rst_dm_rdata", dm_rdata, 32'h0);
      check("rst_mem_addr", mem_address, 32'h0);
      check("rst_mem_wdata", mem_write_data, 32'h0);
      reset = 1'b0;

      do_req("fetch", 1, 0, 32'h0040_0004, 32'h0, 32'h2008_0005, 0, 3);
      do_req("store", 0, 1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 0, 3);
      do_req("load", 0, 0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 0, 3);
      do_req("pool_load", 0, 0, 32'h0040_0004, 32'h0, 32'h2008_0005, 0, 3);

      // Round-robin: both requests from reset, held through four grants.
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      q.push_back('{1, 0, 32'h8C09_0000});
      q.push_back('{0, 0, 32'h1234_5678});
      q.push_back('{1, 0, 32'h8C09_0000});
      q.push_back('{0, 0, 32'h1234_5678});
      if_req = 1'b1; if_addr = 32'h0040_0008;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0004;
      acks = 0;
      cyc = 0;
      while (acks < 4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (if_ack || dm_ack) acks++;
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      check("rr_acks", 32'(acks), 32'd4);
      check("rr_cycles", 32'(cyc), 32'd11);

      do_req("bad_store_text", 0, 1, 32'h0040_0000, 32'h5555_5555, 32'h0, 1, 2);
      do_req("bad_fetch_data", 1, 0, 32'h1001_0000, 32'h0, 32'h0, 1, 2);
      do_req("bad_load_align", 0, 0, 32'h1001_0002, 32'h0, 32'h0, 1, 2);
      do_req("bad_fetch_align", 1, 0, 32'h0040_0006, 32'h0, 32'h0, 1, 2);
      check("text_intact", mem[8], 32'hA000_0008);

      // Reset lands while a store is in ISSUE.
      cyc = 0;
      while (busy && cyc < 10) begin @(negedge clk); cyc++; end
      w0 = wr_cnt;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0010; dm_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      check("mid_busy_issue", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_mem_write", 32'(mem_write), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      dm_req = 1'b0;
      check("mid_busy_after", 32'(busy), 32'd0);
      check("mid_no_ack", 32'({dm_ack, if_ack}), 32'h0);
      repeat (3) @(negedge clk);
      check("mid_mem_unchanged", mem[4], 32'hA000_0004);
      check("sb_drained", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
